// File: rtl/shift_sequencer_pkg.sv
// Shared definitions for the multi-cycle shift unit.
//   op_e    : shift operation encodings (matches ctrl_op)
//   state_e : sequencer FSM states
//   DEF_*   : default operand / shift-amount widths
package shift_sequencer_pkg;

  localparam int unsigned DEF_WIDTH   = 32;
  localparam int unsigned DEF_SHAMT_W = 5;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRA = 2'b01,
    OP_SRL = 2'b10,
    OP_ROR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/shift_sequencer_if.sv
// Request/result handshake bundle of the shift sequencer.
//   in_valid/in_ready         : request handshake (operand, amount, op)
//   ctrl_flush                : synchronous abort
//   out_valid/out_ready       : result handshake, data_result
//   busy                      : unit is in SHIFT or DONE
// master = requester/consumer side, slave = shift_sequencer.
interface shift_sequencer_if #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   data_operandA;
  logic [SHAMT_W-1:0] ctrl_shiftamt;
  logic [1:0]         ctrl_op;
  logic               ctrl_flush;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   data_result;
  logic               busy;

  modport master (
    output in_valid, data_operandA, ctrl_shiftamt, ctrl_op, ctrl_flush, out_ready,
    input  in_ready, out_valid, data_result, busy
  );

  modport slave (
    input  in_valid, data_operandA, ctrl_shiftamt, ctrl_op, ctrl_flush, out_ready,
    output in_ready, out_valid, data_result, busy
  );
endinterface

// File: rtl/shift_sequencer_shift_one_stage.sv
// Single combinational 1-bit shift stage.
//   d  : WIDTH-bit input value
//   op : SLL / SRA / SRL / ROR
//   q  : value shifted by one position
module shift_one_stage
  import shift_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] d,
  input  op_e              op,
  output logic [WIDTH-1:0] q
);
  always_comb begin
    q = d;
    case (op)
      OP_SLL:  q = {d[WIDTH-2:0], 1'b0};
      OP_SRA:  q = {d[WIDTH-1], d[WIDTH-1:1]};
      OP_SRL:  q = {1'b0, d[WIDTH-1:1]};
      OP_ROR:  q = {d[0], d[WIDTH-1:1]};
      default: q = d;
    endcase
  end
endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift controller: latches one request, then applies a single
// 1-bit shift stage once per clock until the shift amount is consumed, and
// presents the result on a valid/ready handshake.
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset
//   io      : request/result handshake bundle (slave side)
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned SHAMT_W = DEF_SHAMT_W
) (
  input  logic            clock,
  input  logic            reset_n,
  shift_sequencer_if.slave io
);
  state_e             state;
  logic [WIDTH-1:0]   sreg;
  logic [WIDTH-1:0]   sreg_next;
  logic [SHAMT_W-1:0] cnt;
  op_e                op;
  logic               out_valid_q;
  logic               busy_q;
  logic               in_ready_q;

  shift_one_stage #(.WIDTH(WIDTH)) u_stage (
    .d  (sreg),
    .op (op),
    .q  (sreg_next)
  );

  // Handshake outputs are registered alongside the state so they change
  // together with it; flush overrides every state and keeps sreg.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      sreg        <= '0;
      cnt         <= '0;
      op          <= OP_SLL;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b1;
    end else if (io.ctrl_flush) begin
      state       <= S_IDLE;
      cnt         <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (io.in_valid) begin
            sreg       <= io.data_operandA;
            cnt        <= io.ctrl_shiftamt;
            op         <= op_e'(io.ctrl_op);
            busy_q     <= 1'b1;
            in_ready_q <= 1'b0;
            if (io.ctrl_shiftamt != '0) begin
              state <= S_SHIFT;
            end else begin
              state       <= S_DONE;
              out_valid_q <= 1'b1;
            end
          end
        end
        S_SHIFT: begin
          sreg <= sreg_next;
          cnt  <= cnt - SHAMT_W'(1);
          if (cnt == SHAMT_W'(1)) begin
            state       <= S_DONE;
            out_valid_q <= 1'b1;
          end
        end
        S_DONE: begin
          if (io.out_ready) begin
            state       <= S_IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state       <= S_IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign io.data_result = sreg;
  assign io.out_valid   = out_valid_q;
  assign io.busy        = busy_q;
  assign io.in_ready    = in_ready_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed steps plus randomized
// transactions checked against an arithmetic reference of the shift ops.
module tb_shift_sequencer;
  import shift_sequencer_pkg::*;

  logic clock;
  logic reset_n;
  int   checks;
  int   errors;

  shift_sequencer_if #(.WIDTH(32), .SHAMT_W(5)) bus ();

  shift_sequencer #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .io      (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference: whole-distance shift computed in one step.
  function automatic logic [31:0] ref_shift(input logic [31:0] a, input int amt,
                                            input logic [1:0] opc);
    logic [31:0] r;
    case (opc)
      2'b00:   r = a << amt;
      2'b01:   r = $unsigned($signed(a) >>> amt);
      2'b10:   r = a >> amt;
      default: r = (amt == 0) ? a : ((a >> amt) | (a << (32 - amt)));
    endcase
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_in_ready"},  32'(bus.in_ready),  32'd1);
    check({tag, "_busy"},      32'(bus.busy),      32'd0);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
  endtask

  // One full transaction: accept, wait for result, backpressure, handshake.
  task automatic do_op(input string tag, input logic [31:0] a, input int amt,
                       input logic [1:0] opc, input int hold);
    logic [31:0] exp;
    int lat;
    exp = ref_shift(a, amt, opc);
    check({tag, "_ready_before"}, 32'(bus.in_ready), 32'd1);
    bus.data_operandA = a;
    bus.ctrl_shiftamt = 5'(amt);
    bus.ctrl_op       = opc;
    bus.in_valid      = 1'b1;
    tick();
    // Inputs are only sampled on the accepting edge.
    bus.data_operandA = $urandom;
    bus.ctrl_shiftamt = 5'($urandom);
    bus.ctrl_op       = 2'($urandom);
    bus.in_valid      = 1'($urandom);
    lat = 1;
    while (!bus.out_valid && lat < 64) begin
      if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin
        check({tag, "_shift_busy"}, {30'd0, bus.in_ready, bus.busy}, 32'd1);
      end
      tick();
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(amt + 1));
    if (!bus.out_valid) return;
    check({tag, "_result"}, bus.data_result, exp);
    check({tag, "_done_ready"}, 32'(bus.in_ready), 32'd0);
    bus.out_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
      check({tag, "_hold_data"}, bus.data_result, exp);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check_idle({tag, "_after"});
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.data_operandA = '0;
    bus.ctrl_shiftamt = '0;
    bus.ctrl_op = '0;
    bus.ctrl_flush = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    check_idle("reset");
    check("reset_data", bus.data_result, 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    tick();

    do_op("sra4",  32'h8000_0010, 4,  OP_SRA, 0);
    do_op("zero",  32'h1234_5678, 0,  OP_SLL, 1);
    do_op("max31", 32'h0000_0001, 31, OP_SLL, 5);
    do_op("srl4",  32'hF000_000F, 4,  OP_SRL, 0);
    do_op("ror4",  32'hF000_000F, 4,  OP_ROR, 2);

    // Flush during SHIFT: back to IDLE, no result ever presented.
    bus.data_operandA = 32'hDEAD_BEEF;
    bus.ctrl_shiftamt = 5'd20;
    bus.ctrl_op = OP_SRL;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (5) tick();
    bus.ctrl_flush = 1'b1;
    tick();
    bus.ctrl_flush = 1'b0;
    check_idle("flush_shift");
    for (int i = 0; i < 25; i++) begin
      tick();
      if (bus.out_valid !== 1'b0) check("flush_no_valid", 32'(bus.out_valid), 32'd0);
    end
    check_idle("flush_quiet");
    do_op("post_flush", 32'h0000_0010, 1, OP_SRL, 0);

    // Flush together with in_valid in IDLE: nothing accepted.
    bus.data_operandA = 32'h5555_AAAA;
    bus.ctrl_shiftamt = 5'd3;
    bus.in_valid = 1'b1;
    bus.ctrl_flush = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.ctrl_flush = 1'b0;
    check_idle("flush_idle");
    check("flush_idle_data", bus.data_result, 32'h0000_0008);

    // Flush together with out_ready in DONE: IDLE, register retained.
    bus.data_operandA = 32'h0000_00F0;
    bus.ctrl_shiftamt = 5'd0;
    bus.ctrl_op = OP_SLL;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    check("done_valid", 32'(bus.out_valid), 32'd1);
    bus.out_ready = 1'b1;
    bus.ctrl_flush = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    bus.ctrl_flush = 1'b0;
    check_idle("flush_done");
    check("flush_done_data", bus.data_result, 32'h0000_00F0);

    // Randomized transactions.
    for (int t = 0; t < 24; t++) begin
      do_op($sformatf("rnd%0d", t), $urandom, int'($urandom_range(0, 31)),
            2'($urandom), int'($urandom_range(0, 3)));
    end

    // Asynchronous reset between edges during SHIFT.
    bus.data_operandA = 32'hFFFF_0000;
    bus.ctrl_shiftamt = 5'd31;
    bus.ctrl_op = OP_ROR;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (3) tick();
    check("pre_areset_busy", 32'(bus.busy), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check_idle("areset");
    check("areset_data", bus.data_result, 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    check_idle("areset_release");
    do_op("after_reset", 32'h8000_0001, 1, OP_ROR, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
